// File: rtl/des_pkg.sv
// des_pkg: shared constants, tables and helper functions for the DES round engine.
// Contents: round count, FSM state enum, IP/FP/E/P index tables (1-based, DES
// bit order: DES bit 1 is the MSB of the vector), S-box tables S1..S8, and the
// permutation/expansion/substitution functions used by the datapath.
package des_pkg;

    localparam int unsigned NUM_ROUNDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_OUT   = 2'd2
    } state_e;

    localparam logic [6:0] IP_T [64] = '{
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [6:0] FP_T [64] = '{
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    localparam logic [5:0] E_T [48] = '{
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    localparam logic [5:0] P_T [32] = '{
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    // S-box entry n = row*16 + col; entry 0 is the leftmost nibble.
    localparam logic [0:63][3:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [0:63][3:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [0:63][3:0] S3 = 256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [0:63][3:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [0:63][3:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [0:63][3:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [0:63][3:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [0:63][3:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    // Output DES bit i takes input DES bit T[i]; DES bit k of an N-bit vector is vec[N-k].
    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[6'(63 - i)] = x[6'(7'd64 - IP_T[i])];
        end
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        y = 64'd0;
        for (int i = 0; i < 64; i++) begin
            y[6'(63 - i)] = x[6'(7'd64 - FP_T[i])];
        end
        return y;
    endfunction

    function automatic logic [47:0] expand(input logic [31:0] r);
        logic [47:0] e;
        e = 48'd0;
        for (int i = 0; i < 48; i++) begin
            e[6'(47 - i)] = r[5'(6'd32 - E_T[i])];
        end
        return e;
    endfunction

    function automatic logic [31:0] pperm(input logic [31:0] s);
        logic [31:0] p;
        p = 32'd0;
        for (int i = 0; i < 32; i++) begin
            p[5'(31 - i)] = s[5'(6'd32 - P_T[i])];
        end
        return p;
    endfunction

    function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] idx);
        logic [3:0] v;
        case (box)
            3'd0:    v = S1[idx];
            3'd1:    v = S2[idx];
            3'd2:    v = S3[idx];
            3'd3:    v = S4[idx];
            3'd4:    v = S5[idx];
            3'd5:    v = S6[idx];
            3'd6:    v = S7[idx];
            3'd7:    v = S8[idx];
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    // Each 6-bit group: outer bits (1st, 6th) pick the row, inner four the column.
    function automatic logic [31:0] sbox(input logic [47:0] x);
        logic [31:0] y;
        logic [5:0]  six;
        logic [5:0]  idx;
        y = 32'd0;
        for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            idx = {six[5], six[0], six[4:1]};
            y   = y | (32'(sbox_lookup(3'(b), idx)) << (28 - 4 * b));
        end
        return y;
    endfunction

endpackage

// File: rtl/des_feistel_f.sv
// des_feistel_f: combinational DES round function f(R, K) = P(S(E(R) ^ K)).
// Ports:
//   r_i [31:0]  right half, DES bit order (r_i[31] = bit 1)
//   k_i [47:0]  round subkey, DES bit order (k_i[47] = bit 1)
//   f_o [31:0]  round function output
module des_feistel_f
    import des_pkg::*;
(
    input  logic [31:0] r_i,
    input  logic [47:0] k_i,
    output logic [31:0] f_o
);

    assign f_o = pperm(sbox(expand(r_i) ^ k_i));

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES encrypt/decrypt, one Feistel round per clock.
// Applies IP on load and FP on output, so data_out_o is a complete DES result.
// Ports:
//   clk_i                     clock, rising edge
//   rst_n_i                   synchronous active-low reset
//   start_i                   process data_in_i; honoured only when idle
//   decrypt_i                 0 = encrypt (K1..K16), 1 = decrypt (K16..K1)
//   data_in_i [63:0]          input block, data_in_i[63] = DES bit 1
//   sub_key1_i..sub_key16_i   round subkeys, stable while busy_o = 1
//   data_out_o [63:0]         registered result, held until the next completion
//   done_o                    one-cycle pulse, data_out_o valid from this cycle
//   busy_o                    high from the cycle after accept through the done cycle
module des_round_engine
    import des_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        decrypt_i,
    input  logic [63:0] data_in_i,
    input  logic [47:0] sub_key1_i,
    input  logic [47:0] sub_key2_i,
    input  logic [47:0] sub_key3_i,
    input  logic [47:0] sub_key4_i,
    input  logic [47:0] sub_key5_i,
    input  logic [47:0] sub_key6_i,
    input  logic [47:0] sub_key7_i,
    input  logic [47:0] sub_key8_i,
    input  logic [47:0] sub_key9_i,
    input  logic [47:0] sub_key10_i,
    input  logic [47:0] sub_key11_i,
    input  logic [47:0] sub_key12_i,
    input  logic [47:0] sub_key13_i,
    input  logic [47:0] sub_key14_i,
    input  logic [47:0] sub_key15_i,
    input  logic [47:0] sub_key16_i,
    output logic [63:0] data_out_o,
    output logic        done_o,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d;
    logic [31:0] r_q, r_d;
    logic        dir_q, dir_d;
    logic [63:0] data_out_q, data_out_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic [47:0] sub_keys_s [NUM_ROUNDS];
    logic [3:0]  key_sel_s;
    logic [47:0] round_key_s;
    logic [31:0] f_s;

    assign sub_keys_s[0]  = sub_key1_i;
    assign sub_keys_s[1]  = sub_key2_i;
    assign sub_keys_s[2]  = sub_key3_i;
    assign sub_keys_s[3]  = sub_key4_i;
    assign sub_keys_s[4]  = sub_key5_i;
    assign sub_keys_s[5]  = sub_key6_i;
    assign sub_keys_s[6]  = sub_key7_i;
    assign sub_keys_s[7]  = sub_key8_i;
    assign sub_keys_s[8]  = sub_key9_i;
    assign sub_keys_s[9]  = sub_key10_i;
    assign sub_keys_s[10] = sub_key11_i;
    assign sub_keys_s[11] = sub_key12_i;
    assign sub_keys_s[12] = sub_key13_i;
    assign sub_keys_s[13] = sub_key14_i;
    assign sub_keys_s[14] = sub_key15_i;
    assign sub_keys_s[15] = sub_key16_i;

    // Subkey select: decryption walks the schedule backwards.
    always_comb begin
        if (dir_q) begin
            key_sel_s = 4'd15 - cnt_q;
        end else begin
            key_sel_s = cnt_q;
        end
        round_key_s = sub_keys_s[key_sel_s];
    end

    des_feistel_f u_feistel (
        .r_i (r_q),
        .k_i (round_key_s),
        .f_o (f_s)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        l_d        = l_q;
        r_d        = r_q;
        dir_d      = dir_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                // busy stays high across the done cycle when a new block is accepted.
                busy_d = start_i;
                if (start_i) begin
                    {l_d, r_d} = ip(data_in_i);
                    dir_d      = decrypt_i;
                    cnt_d      = 4'd0;
                    state_d    = ST_ROUND;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_ROUND: begin
                l_d    = r_q;
                r_d    = l_q ^ f_s;
                cnt_d  = cnt_q + 4'd1;
                busy_d = 1'b1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_OUT: begin
                // {R, L} undoes the swap performed by the last round.
                data_out_d = fp({r_q, l_q});
                done_d     = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            l_q        <= 32'd0;
            r_q        <= 32'd0;
            dir_q      <= 1'b0;
            data_out_q <= 64'd0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            l_q        <= l_d;
            r_q        <= r_d;
            dir_q      <= dir_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out_o = data_out_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed self-checking bench for des_round_engine.
// Derives the 16 subkeys from a 64-bit key with its own key schedule and
// checks results against published DES vectors.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] data_in;
    logic [47:0] ks [16];
    logic [63:0] data_out;
    logic        done;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .decrypt_i   (decrypt),
        .data_in_i   (data_in),
        .sub_key1_i  (ks[0]),
        .sub_key2_i  (ks[1]),
        .sub_key3_i  (ks[2]),
        .sub_key4_i  (ks[3]),
        .sub_key5_i  (ks[4]),
        .sub_key6_i  (ks[5]),
        .sub_key7_i  (ks[6]),
        .sub_key8_i  (ks[7]),
        .sub_key9_i  (ks[8]),
        .sub_key10_i (ks[9]),
        .sub_key11_i (ks[10]),
        .sub_key12_i (ks[11]),
        .sub_key13_i (ks[12]),
        .sub_key14_i (ks[13]),
        .sub_key15_i (ks[14]),
        .sub_key16_i (ks[15]),
        .data_out_o  (data_out),
        .done_o      (done),
        .busy_o      (busy)
    );

    task automatic make_keys(input logic [63:0] key);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int s = 0; s < SHIFTS[n]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][47 - i] = cd[56 - PC2[i]];
        end
    endtask

    // Drives start for exactly one rising edge; returns at the negedge after it.
    task automatic start_pulse(input logic [63:0] d, input logic dec);
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        decrypt = dec;
        @(negedge clk);
        start   = 1'b0;
        data_in = 64'hA5A5_5A5A_F00F_0FF0;
    endtask

    // Counts rising edges until done is seen at a negedge, bounded at 40.
    task automatic wait_done(output int edges, output bit got);
        edges = 0;
        got   = 1'b0;
        while (edges < 40 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (data_out !== 64'd0) begin miscompares++; $display("FAIL rst_data_out: got %h expected %h", data_out, 64'd0); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_encrypt();
        int edges;
        bit got;
        make_keys(64'h1334_5779_9BBC_DFF1);
        start_pulse(64'h0123_4567_89AB_CDEF, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL enc_busy_rise: got %b expected 1", busy); end
        wait_done(edges, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL enc_timeout: got done=%b expected 1", got); end
        vectors++; if (edges != 17) begin miscompares++; $display("FAIL enc_latency: got %0d expected 17", edges); end
        vectors++; if (data_out !== 64'h85E8_1354_0F0A_B405) begin miscompares++; $display("FAIL enc_data: got %h expected 85e813540f0ab405", data_out); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL enc_busy_done: got %b expected 1", busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL enc_done_pulse: got %b expected 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL enc_busy_fall: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (data_out !== 64'h85E8_1354_0F0A_B405) begin miscompares++; $display("FAIL enc_hold: got %h expected 85e813540f0ab405", data_out); end
    endtask

    task automatic test_decrypt();
        int edges;
        bit got;
        make_keys(64'h1334_5779_9BBC_DFF1);
        start_pulse(64'h85E8_1354_0F0A_B405, 1'b1);
        wait_done(edges, got);
        vectors++; if (edges != 17) begin miscompares++; $display("FAIL dec_latency: got %0d expected 17", edges); end
        vectors++; if (data_out !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL dec_data: got %h expected 0123456789abcdef", data_out); end
    endtask

    task automatic test_encrypt_zero();
        int edges;
        bit got;
        make_keys(64'h0E32_9232_EA6D_0D73);
        start_pulse(64'h8787_8787_8787_8787, 1'b0);
        wait_done(edges, got);
        vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL enc2_timeout: got done=%b expected 1", got); end
        vectors++; if (data_out !== 64'h0000_0000_0000_0000) begin miscompares++; $display("FAIL enc2_data: got %h expected 0000000000000000", data_out); end
    endtask

    task automatic test_start_while_busy();
        int edges;
        bit got;
        bit busy_low;
        make_keys(64'h1334_5779_9BBC_DFF1);
        start_pulse(64'h0123_4567_89AB_CDEF, 1'b0);
        busy_low = 1'b0;
        edges = 0;
        got = 1'b0;
        while (edges < 40 && !got) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy !== 1'b1) busy_low = 1'b1;
            if (edges == 4) begin
                start = 1'b1;
                data_in = 64'h8787_8787_8787_8787;
                decrypt = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
        end
        vectors++; if (edges != 17) begin miscompares++; $display("FAIL ign_latency: got %0d expected 17", edges); end
        vectors++; if (data_out !== 64'h85E8_1354_0F0A_B405) begin miscompares++; $display("FAIL ign_first_data: got %h expected 85e813540f0ab405", data_out); end
        // Start during the done cycle: second block decrypts the first result.
        start = 1'b1;
        data_in = 64'h85E8_1354_0F0A_B405;
        decrypt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL ign_done_fall: got %b expected 0", done); end
        if (busy !== 1'b1) busy_low = 1'b1;
        wait_done(edges, got);
        vectors++; if (edges != 17) begin miscompares++; $display("FAIL ign_second_latency: got %0d expected 17", edges); end
        vectors++; if (data_out !== 64'h0123_4567_89AB_CDEF) begin miscompares++; $display("FAIL ign_second_data: got %h expected 0123456789abcdef", data_out); end
        vectors++; if (busy_low !== 1'b0) begin miscompares++; $display("FAIL ign_busy_gap: got busy_low=%b expected 0", busy_low); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int edges;
        bit got;
        bit saw_done;
        make_keys(64'h1334_5779_9BBC_DFF1);
        start_pulse(64'h0123_4567_89AB_CDEF, 1'b0);
        edges = 0;
        while (edges < 7) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        vectors++; if (data_out !== 64'd0) begin miscompares++; $display("FAIL mid_rst_data: got %h expected 0", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL mid_no_done: got saw_done=%b expected 0", saw_done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_idle_busy: got %b expected 0", busy); end
        start_pulse(64'h0123_4567_89AB_CDEF, 1'b0);
        wait_done(edges, got);
        vectors++; if (data_out !== 64'h85E8_1354_0F0A_B405) begin miscompares++; $display("FAIL mid_fresh_data: got %h expected 85e813540f0ab405", data_out); end
    endtask

    task automatic test_back_to_back();
        int edges;
        int ndone;
        int t [3];
        bit busy_low;
        @(negedge clk);
        start = 1'b1;
        data_in = 64'h0123_4567_89AB_CDEF;
        decrypt = 1'b0;
        edges = 0;
        ndone = 0;
        busy_low = 1'b0;
        t = '{0, 0, 0};
        while (edges < 80 && ndone < 3) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy !== 1'b1) busy_low = 1'b1;
            if (done === 1'b1) begin
                t[ndone] = edges;
                vectors++; if (data_out !== 64'h85E8_1354_0F0A_B405) begin miscompares++; $display("FAIL b2b_data%0d: got %h expected 85e813540f0ab405", ndone, data_out); end
                ndone++;
                if (ndone == 3) start = 1'b0;
            end
        end
        vectors++; if (ndone != 3) begin miscompares++; $display("FAIL b2b_count: got %0d expected 3", ndone); end
        vectors++; if (t[0] != 18) begin miscompares++; $display("FAIL b2b_first: got %0d expected 18", t[0]); end
        vectors++; if (t[1] - t[0] != 18) begin miscompares++; $display("FAIL b2b_gap1: got %0d expected 18", t[1] - t[0]); end
        vectors++; if (t[2] - t[1] != 18) begin miscompares++; $display("FAIL b2b_gap2: got %0d expected 18", t[2] - t[1]); end
        vectors++; if (busy_low !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_gap: got busy_low=%b expected 0", busy_low); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        decrypt = 1'b0;
        data_in = 64'd0;
        for (int n = 0; n < 16; n++) ks[n] = 48'd0;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_encrypt_zero();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
